// File: rtl/car_speed_tick.sv
// Game-speed tick generator: one-cycle Tick pulses at BASE_DIV >> level cycles, with a Distance count of Ticks issued.
// Optional CAR_SPEED_RAMP_EN: at each boundary Level steps one level toward the request instead of jumping to it.
module car_speed_tick #(
  parameter int BASE_DIV   = 25000000,
  parameter int NUM_LEVELS = 3,
  parameter int DIST_W     = 16,
  localparam int LW        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [NUM_LEVELS-1:0] SW,
  input  logic                  Pause,
  input  logic                  Clear,
  output logic                  Tick,
  output logic [LW-1:0]         Level,
  output logic                  Running,
  output logic [DIST_W-1:0]     Distance
);

  localparam int CW = $clog2(BASE_DIV);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NUM_LEVELS-1:0] sw_q_r;
  logic [0:0]            state_r;
  logic [CW-1:0]         count_r;
  logic [LW-1:0]         level_r;
  logic [DIST_W-1:0]     dist_r;
  logic                  sw_valid_s;
  logic [LW-1:0]         req_level_s;
  logic [LW-1:0]         next_level_s;
  logic                  tick_s;

  // Reload value for a level; the loop unrolls into a constant table.
  function automatic logic [CW-1:0] period_m1(input logic [LW-1:0] lvl);
    logic [CW-1:0] r;
    r = CW'(BASE_DIV - 1);
    for (int k = 0; k < NUM_LEVELS; k++) begin
      r = (lvl == LW'(k)) ? CW'((BASE_DIV >> k) - 1) : r;
    end
    return r;
  endfunction

  // Selection decode, level update rule and the boundary pulse.
  always_comb begin
    sw_valid_s  = $onehot(sw_q_r);
    req_level_s = LW'(0);
    for (int k = 0; k < NUM_LEVELS; k++) begin
      req_level_s = sw_q_r[k] ? LW'(k) : req_level_s;
    end
`ifdef CAR_SPEED_RAMP_EN
    if (req_level_s > level_r) begin
      next_level_s = level_r + LW'(1);
    end else if (req_level_s < level_r) begin
      next_level_s = level_r - LW'(1);
    end else begin
      next_level_s = level_r;
    end
`else
    next_level_s = req_level_s;
`endif
    tick_s = (state_r == ST_RUN) && sw_valid_s && !Pause &&
             (count_r == CW'(0)) && !Reset;
  end

  // Input register, run/idle control and period counter.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sw_q_r  <= '0;
      state_r <= ST_IDLE;
      count_r <= CW'(0);
      level_r <= LW'(0);
    end else begin
      sw_q_r <= SW;
      case (state_r)
        ST_IDLE: begin
          if (sw_valid_s) begin
            state_r <= ST_RUN;
            level_r <= req_level_s;
            count_r <= period_m1(req_level_s);
          end else begin
            count_r <= CW'(0);
          end
        end
        ST_RUN: begin
          if (!sw_valid_s) begin
            state_r <= ST_IDLE;
            count_r <= CW'(0);
          end else if (tick_s) begin
            // Rate changes only land here, so no period is cut short or stretched.
            level_r <= next_level_s;
            count_r <= period_m1(next_level_s);
          end else if (!Pause) begin
            count_r <= count_r - CW'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= CW'(0);
        end
      endcase
    end
  end

  // Distance odometer; Clear overrides a coincident Tick.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      dist_r <= DIST_W'(0);
    end else if (Clear) begin
      dist_r <= DIST_W'(0);
    end else if (tick_s) begin
      dist_r <= dist_r + DIST_W'(1);
    end else begin
      dist_r <= dist_r;
    end
  end

  assign Tick     = tick_s;
  assign Level    = level_r;
  assign Running  = (state_r == ST_RUN);
  assign Distance = dist_r;

endmodule
